div8_signed: RTL and testbench

Sequential signed divider: 8-bit two's-complement dividend by 4-bit two's-complement divisor, producing an 8-bit quotient and a 4-bit remainder. It is the inverse companion of the team's shift-add signed multiplier and uses the same start/done handshake. The datapath is restoring division on magnitudes, with sign correction at the end. Rounding is truncation toward zero, and the remainder takes the sign of the dividend, matching Verilog `/` and `%`.

---
 rtl/div8_signed_if.sv | 37 +++
 rtl/div8_signed.sv | 155 +++++++++++++++
 tb/tb_div8_signed.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/div8_signed_if.sv
// ----------------------------------------------------------------------------
// div8_signed_if
//   Start/done handshake and operand/result bundle for the sequential signed
//   divider. The master requests a division and reads the results, and the
//   slave (the divider) performs it.
//
//   start      master -> slave  request, sampled only while the divider is idle
//   dividend   master -> slave  8-bit signed dividend
//   divisor    master -> slave  4-bit signed divisor
//   quotient   slave -> master  8-bit signed quotient
//   remainder  slave -> master  4-bit signed remainder
//   done       slave -> master  one-cycle completion pulse
//   busy       slave -> master  division in flight
//   div_zero   slave -> master  last division had a zero divisor
//   ovf        slave -> master  last division was -128 / -1
// ----------------------------------------------------------------------------
interface div8_signed_if;
    logic               start;
    logic signed [7:0]  dividend;
    logic signed [3:0]  divisor;
    logic signed [7:0]  quotient;
    logic signed [3:0]  remainder;
    logic               done;
    logic               busy;
    logic               div_zero;
    logic               ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, busy, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, busy, div_zero, ovf
    );
endinterface

// File: rtl/div8_signed.sv
// ----------------------------------------------------------------------------
// div8_signed
//   Sequential signed divider: 8-bit dividend / 4-bit divisor -> 8-bit
//   quotient and 4-bit remainder. Restoring division is run on magnitudes
//   for 8 iterations, then signs are applied so the quotient truncates toward
//   zero and the remainder follows the dividend's sign.
//   Timeline: 1 capture edge + 8 iteration edges + 1 fix edge; done pulses
//   for one cycle after the fix edge.
//
//   clk   in   rising-edge clock
//   rstn  in   synchronous active-low reset
//   bus   slave modport of div8_signed_if (start/operands in, results out)
// ----------------------------------------------------------------------------
module div8_signed (
    input  logic          clk,
    input  logic          rstn,
    div8_signed_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [8:0]         r_dmag;     // |dividend|, 9 bits so 128 is representable
    logic [4:0]         r_vmag;     // |divisor|, up to 8
    logic [4:0]         r_p;        // partial remainder
    logic [7:0]         r_q;        // working quotient magnitude
    logic               r_qsign;
    logic               r_rsign;
    logic               r_zflag;
    logic [3:0]         r_count;

    logic signed [7:0]  r_quotient;
    logic signed [3:0]  r_remainder;
    logic               r_done;
    logic               r_busy;
    logic               r_div_zero;
    logic               r_ovf;

    // Magnitude of a signed dividend, widened so -128 maps to +128.
    function automatic logic [8:0] mag8(input logic signed [7:0] x);
        logic signed [8:0] e;
        e = {x[7], x};
        if (e < 0) e = -e;
        return e;
    endfunction

    // Magnitude of a signed divisor; -8 maps to +8.
    function automatic logic [4:0] mag4(input logic signed [3:0] x);
        logic signed [4:0] e;
        e = {x[3], x};
        if (e < 0) e = -e;
        return e;
    endfunction

    // Conditional two's-complement negation for the final sign fix-up.
    function automatic logic [7:0] apply_sign8(input logic s, input logic [7:0] v);
        return s ? -v : v;
    endfunction

    function automatic logic [3:0] apply_sign4(input logic s, input logic [3:0] v);
        return s ? -v : v;
    endfunction

    // One restoring step: bring down the next dividend bit and trial-subtract.
    // T is formed one bit wider than P so every P bit participates; the
    // result always fits back in 5 bits because P stays below |divisor| <= 8.
    logic [5:0] w_t;
    logic       w_ge;
    logic [4:0] w_pnext;

    always_comb begin
        w_t     = {r_p, r_dmag[7]};
        w_ge    = (w_t >= {1'b0, r_vmag});
        w_pnext = w_ge ? 5'(w_t - {1'b0, r_vmag}) : w_t[4:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_dmag      <= '0;
            r_vmag      <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_zflag     <= 1'b0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dmag  <= mag8(bus.dividend);
                        r_vmag  <= mag4(bus.divisor);
                        r_qsign <= bus.dividend[7] ^ bus.divisor[3];
                        r_rsign <= bus.dividend[7];
                        r_zflag <= (bus.divisor == 4'sd0);
                        r_p     <= '0;
                        r_q     <= '0;
                        r_count <= 4'd8;
                        r_busy  <= 1'b1;
                        r_state <= S_ITER;
                    end
                end

                S_ITER: begin
                    r_p     <= w_pnext;
                    r_q     <= {r_q[6:0], w_ge};
                    r_dmag  <= r_dmag << 1;
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) r_state <= S_FIX;
                end

                S_FIX: begin
                    if (r_zflag) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_div_zero  <= 1'b1;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_quotient  <= apply_sign8(r_qsign, r_q);
                        r_remainder <= apply_sign4(r_rsign, r_p[3:0]);
                        r_div_zero  <= 1'b0;
                        // A positive quotient with bit 7 set can only be
                        // 128 from -128 / -1, which is not representable.
                        r_ovf       <= ~r_qsign & r_q[7];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.div_zero  = r_div_zero;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_div8_signed.sv
// ----------------------------------------------------------------------------
// tb_div8_signed
//   Directed bench for div8_signed: a table of operand/result records run
//   through the start/done handshake, plus hand-written sequences for
//   back-to-back starts, ignored starts, operand changes and mid-op reset.
// ----------------------------------------------------------------------------
module tb_div8_signed;

    logic clk;
    logic rstn;

    div8_signed_if bus_if ();

    div8_signed dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        logic       o;
    } vec_t;

    int n_cmp;
    int n_bad;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts one division, waits for done (bounded) and checks latency and
    // that busy stayed high until the done cycle. Leaves time in the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input string tag);
        int n;
        bit busy_ok;
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.start    = 1'b1;
        step();
        bus_if.start = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!bus_if.done && n < 20) begin
            if (!bus_if.busy) busy_ok = 1'b0;
            step();
            n++;
        end
        check({tag, " latency"}, n, 10);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [3:0] r,
                                input logic z, input logic o);
        check({tag, " quotient"},  {24'd0, bus_if.quotient},  {24'd0, q});
        check({tag, " remainder"}, {28'd0, bus_if.remainder}, {28'd0, r});
        check({tag, " div_zero"},  {31'd0, bus_if.div_zero},  {31'd0, z});
        check({tag, " ovf"},       {31'd0, bus_if.ovf},       {31'd0, o});
    endtask

    vec_t vecs[15];

    initial begin
        int ndone;
        n_cmp = 0;
        n_bad = 0;

        //            a       b       q       r      z     o
        vecs[0]  = '{8'd100, 4'd7,   8'h0E, 4'h2, 1'b0, 1'b0};  //  100 /  7
        vecs[1]  = '{8'h9C,  4'd7,   8'hF2, 4'hE, 1'b0, 1'b0};  // -100 /  7
        vecs[2]  = '{8'd100, 4'h9,   8'hF2, 4'h2, 1'b0, 1'b0};  //  100 / -7
        vecs[3]  = '{8'h9C,  4'h9,   8'h0E, 4'hE, 1'b0, 1'b0};  // -100 / -7
        vecs[4]  = '{8'h80,  4'hF,   8'h80, 4'h0, 1'b0, 1'b1};  // -128 / -1
        vecs[5]  = '{8'h80,  4'h8,   8'h10, 4'h0, 1'b0, 1'b0};  // -128 / -8
        vecs[6]  = '{8'hF9,  4'h8,   8'h00, 4'h9, 1'b0, 1'b0};  //   -7 / -8
        vecs[7]  = '{8'd0,   4'd5,   8'h00, 4'h0, 1'b0, 1'b0};  //    0 /  5
        vecs[8]  = '{8'd5,   4'd0,   8'h00, 4'h0, 1'b1, 1'b0};  //    5 /  0
        vecs[9]  = '{8'd9,   4'd3,   8'h03, 4'h0, 1'b0, 1'b0};  //    9 /  3
        vecs[10] = '{8'd127, 4'd7,   8'h12, 4'h1, 1'b0, 1'b0};  //  127 /  7
        vecs[11] = '{8'hFF,  4'd1,   8'hFF, 4'h0, 1'b0, 1'b0};  //   -1 /  1
        vecs[12] = '{8'd127, 4'hF,   8'h81, 4'h0, 1'b0, 1'b0};  //  127 / -1
        vecs[13] = '{8'd7,   4'h8,   8'h00, 4'h7, 1'b0, 1'b0};  //    7 / -8
        vecs[14] = '{8'h80,  4'd3,   8'hD6, 4'hE, 1'b0, 1'b0};  // -128 /  3

        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        check("reset done", {31'd0, bus_if.done}, 32'd0);
        check("reset busy", {31'd0, bus_if.busy}, 32'd0);
        check_result("reset", 8'h00, 4'h0, 1'b0, 1'b0);

        // Table-driven operations
        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].a, vecs[i].b, tag);
            check_result(tag, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o);
            step();
            check({tag, " done width"}, {31'd0, bus_if.done}, 32'd0);
            check({tag, " hold q"}, {24'd0, bus_if.quotient}, {24'd0, vecs[i].q});
        end

        // start held high: 50/6 then 50/-6, second taken in the done cycle;
        // operands change right after the first capture edge.
        bus_if.dividend = 8'd50;
        bus_if.divisor  = 4'd6;
        bus_if.start    = 1'b1;
        step();
        bus_if.dividend = 8'd50;
        bus_if.divisor  = 4'hA;  // -6
        begin
            int n;
            n = 1;
            while (!bus_if.done && n < 20) begin step(); n++; end
            check("b2b first latency", n, 10);
            check_result("b2b first", 8'h08, 4'h2, 1'b0, 1'b0);
            step();
            bus_if.start = 1'b0;
            check("b2b restart busy", {31'd0, bus_if.busy}, 32'd1);
            check("b2b restart done", {31'd0, bus_if.done}, 32'd0);
            n = 1;
            while (!bus_if.done && n < 20) begin step(); n++; end
            check("b2b second latency", n, 10);
            check_result("b2b second", 8'hF8, 4'h2, 1'b0, 1'b0);
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus_if.done) ndone++;
        end
        check("b2b extra dones", ndone, 0);

        // start pulses while busy are ignored
        bus_if.dividend = 8'd50;
        bus_if.divisor  = 4'd6;
        bus_if.start    = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        step();
        bus_if.dividend = 8'd1;
        bus_if.divisor  = 4'd1;
        bus_if.start    = 1'b1;
        step();
        bus_if.start = 1'b0;
        begin
            int n;
            n = 4;
            while (!bus_if.done && n < 20) begin step(); n++; end
            check("busy-start latency", n, 10);
            check_result("busy-start", 8'h08, 4'h2, 1'b0, 1'b0);
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus_if.done) ndone++;
        end
        check("busy-start extra dones", ndone, 0);

        // Reset in the middle of a division
        bus_if.dividend = 8'd100;
        bus_if.divisor  = 4'd7;
        bus_if.start    = 1'b1;
        step();
        bus_if.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rstn = 1'b0;
        step();
        check("midrst busy", {31'd0, bus_if.busy}, 32'd0);
        check("midrst done", {31'd0, bus_if.done}, 32'd0);
        check_result("midrst", 8'h00, 4'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus_if.done) ndone++;
        end
        check("midrst no done", ndone, 0);
        run_op(8'd20, 4'd3, "post-reset");
        check_result("post-reset", 8'h06, 4'h2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
